stream_mux_rr: RTL
==================

# stream_mux_rr

Parametrised, registered N-channel stream multiplexer with valid/ready handshakes. It selects one of `N_CH` input channels per cycle, either from an external select or by round-robin arbitration, and presents the chosen beat on a single registered output. It replaces the plain combinational 4:1 data selector wherever sources are flow-controlled and must share one downstream sink.

## Interface
Parameters:
- `WIDTH`, 4: data width per channel.
- `N_CH`, 4: number of input channels, ≥2; need not be a power of two.
- `SEL_W`, `$clog2(N_CH)`: width of the select and channel-index fields.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  `N_CH*WIDTH`  channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  `N_CH`  per-channel beat valid.
- `in_last`  in  `N_CH`  per-channel end-of-packet flag.
- `in_ready`  out  `N_CH`  per-channel accept; one-hot or zero.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  `SEL_W`  channel index used in fixed mode.
- `out_data`  out  `WIDTH`  registered beat.
- `out_last`  out  1  registered `in_last` of the accepted beat.
- `out_sel`  out  `SEL_W`  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accepts.

## Operation
- Single-entry output register. `load = !out_valid || out_ready`.
- Grant:
  - Fixed mode: `g = sel` if `sel < N_CH && in_valid[sel]`; otherwise no grant.
  - Round-robin mode: first channel with `in_valid` set, searching from `ptr+1` upward with wrap-around past `N_CH-1` to 0. The channel at `ptr` is searched last.
- `in_ready[g] = load` for the granted channel only. All other `in_ready` bits are 0.
- A transfer occurs when `load` is set and a grant exists. On transfer: `out_data <= in_data[g]`, `out_last <= in_last[g]`, `out_sel <= g`, `out_valid <= 1`, `ptr <= g`. `ptr` updates in both modes.
- If `load` is set and there is no grant: `out_valid <= 0`. `out_data`, `out_last` and `out_sel` keep their values.
- While `out_valid && !out_ready`, all output signals hold stable.
- A change on `mode` or `sel` takes effect on the same cycle's grant. `ptr` is preserved across mode changes.
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`, `ptr=N_CH-1` so the first round-robin search starts at channel 0, lock cleared.
- Reset asserted mid-operation: the held beat is discarded, `in_ready` is all-zero during reset, and no transfer is counted.

## Timing
- Latency is 1 cycle from input handshake to `out_valid`. Throughput is 1 beat per cycle with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, `sel` and lock state.
- `out_valid` and `out_data` are pure register outputs, with no combinational path from the inputs.
- A simultaneous drain and load in one cycle is legal and keeps full throughput.

## Configuration
- `STREAM_MUX_PKT_LOCK_EN` defined:
  - A transfer with `in_last=0` sets `lock` and records `lock_ch=g`.
  - While locked, the grant is restricted to `lock_ch` in both modes. `sel` and the round-robin search are ignored.
  - A transfer from `lock_ch` with `in_last=1` clears `lock`.
  - Reset clears `lock`.
- Not defined: no lock logic; every beat is arbitrated independently. `in_last` is still forwarded to `out_last`.

## Structure
- Package `stream_mux_pkg`:
  - `mode_e` with `MODE_FIXED=1'b0` and `MODE_RR=1'b1`.
  - Reset constants for `ptr` and the output register.
- Sub-module `rr_arbiter`: purely combinational, parameters `N_CH` and `SEL_W`. Inputs are `req[N_CH]` and `ptr`; outputs are `gnt_valid` and `gnt_idx`. It implements the wrap-around search.
- Top level holds the output register, `ptr`, lock state, fixed-mode select and `in_ready` decode.

## Test plan
- Reset, then `mode=0`, `sel=2`, `in_valid=4'b0100`, `in_data[2]=4'hA`, `out_ready=1` -> `in_ready=4'b0100`; next cycle `out_valid=1`, `out_data=4'hA`, `out_sel=2`.
- `mode=1`, all four channels valid continuously with data `{D,C,B,A}`, `out_ready=1` -> grants in order 0,1,2,3,0; `out_data` sequence A,B,C,D,A, one beat per cycle.
- Output full and `out_ready=0` for 3 cycles -> `in_ready=0`; `out_data` and `out_sel` stable; on `out_ready=1`, drain and new load occur in the same cycle.
- `N_CH=3`, `mode=0`, `sel=3` -> no grant, `in_ready=0`; `out_valid` falls after the held beat drains.
- With `STREAM_MUX_PKT_LOCK_EN`, `mode=1`: channel 1 sends 3 beats with `last=0,0,1` while channel 2 is valid -> channel 2 is not granted until the cycle after channel 1's last beat transfers.
- Assert `reset` for 1 cycle while `out_valid=1` and `out_ready=0` -> next cycle `out_valid=0`, `out_data=0`; the first round-robin grant goes to channel 0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_rr shared types: arbitration mode enum and reset constants.
// No ports; imported by the interface, the top and the bench.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam logic OUT_VALID_RST = 1'b0;
  localparam logic OUT_LAST_RST  = 1'b0;

  // Round-robin pointer resets to the last channel so the
  // first search begins at channel 0.
  function automatic int unsigned ptr_rst(int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr bundle: N input streams, select controls, one output stream.
// master = source/sink side (bench), slave = mux side.
interface stream_mux_rr_if #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) ();

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  stream_mux_pkg::mode_e mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_last,
    output mode, sel, out_ready,
    input  in_ready, out_data, out_last,
    input  out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last,
    input  mode, sel, out_ready,
    output in_ready, out_data, out_last,
    output out_sel, out_valid
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational wrap-around search from ptr+1; ptr checked last.
// Ports: req (requests), ptr (last grant) -> gnt_valid, gnt_idx.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W:0] j;

  // Walk offsets from farthest to nearest so the nearest
  // requester after ptr is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = '0;
    for (int k = N_CH; k >= 1; k--) begin
      j = {1'b0, ptr} + (SEL_W+1)'(k);
      if (j >= (SEL_W+1)'(N_CH))
        j = j - (SEL_W+1)'(N_CH);
      for (int i = 0; i < N_CH; i++) begin
        if (req[i] && j == (SEL_W+1)'(i)) begin
          gnt_valid = 1'b1;
          gnt_idx   = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-channel stream mux, fixed or round-robin grant.
// Ports: clk, reset (sync, active-high), bus (stream_mux_rr_if.slave).
// Optional packet lock: define STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input logic           clk,
  input logic           reset,
  stream_mux_rr_if.slave bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load, xfer;
  logic             rr_vld, fix_vld, gnt_vld;
  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;
  logic [N_CH-1:0]  rdy;

  assign load = !out_valid_q || bus.out_ready;

  rr_arbiter #(
    .N_CH (N_CH),
    .SEL_W(SEL_W)
  ) u_arb (
    .req      (bus.in_valid),
    .ptr      (ptr_q),
    .gnt_valid(rr_vld),
    .gnt_idx  (rr_idx)
  );

  // Out-of-range sel matches no channel, so it never grants.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (bus.sel == SEL_W'(i))
        fix_vld = bus.in_valid[i];
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             lock_vld;

  always_comb begin
    lock_vld = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (lock_ch_q == SEL_W'(i))
        lock_vld = bus.in_valid[i];
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    unique case (1'b1)
      lock_q: begin
        gnt_vld = lock_vld;
        gnt_idx = lock_ch_q;
      end
      (!lock_q && bus.mode == MODE_RR): begin
        gnt_vld = rr_vld;
        gnt_idx = rr_idx;
      end
      default: begin
        gnt_vld = fix_vld;
        gnt_idx = bus.sel;
      end
    endcase
  end

  // Mid-packet beat opens the lock; the last beat closes it.
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d = !gnt_last;
      if (!gnt_last)
        lock_ch_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    unique case (1'b1)
      (bus.mode == MODE_RR): begin
        gnt_vld = rr_vld;
        gnt_idx = rr_idx;
      end
      default: begin
        gnt_vld = fix_vld;
        gnt_idx = bus.sel;
      end
    endcase
  end
`endif

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = bus.in_data[i*WIDTH +: WIDTH];
        gnt_last = bus.in_last[i];
      end
    end
  end

  assign xfer = load && gnt_vld && !reset;

  always_comb begin
    rdy = '0;
    for (int i = 0; i < N_CH; i++)
      rdy[i] = xfer && (gnt_idx == SEL_W'(i));
  end

  assign bus.in_ready = rdy;

  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_last_d  = gnt_last;
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      ptr_d       = gnt_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_last_q  <= OUT_LAST_RST;
      out_sel_q   <= '0;
      out_valid_q <= OUT_VALID_RST;
      ptr_q       <= SEL_W'(ptr_rst(N_CH));
    end else begin
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule
